fifo_rd_status: RTL

Read-side status stage of the asynchronous FIFO. It sits directly downstream of the read and write gray-code pointer counters. It synchronises the write-domain gray pointer into the read clock and converts both pointers to binary. From them it generates a registered empty flag, a read-grant that drives the read counter's enable, an optional fill level and almost-empty flag, and a sticky underflow error.

---
 rtl/fifo_rd_status.sv | 133 +++++++++++++
 1 files changed

// File: rtl/fifo_rd_status.sv
// ---------------------------------------------------------------------------
// fifo_rd_status
// Read-side status stage of an asynchronous FIFO. It brings the write-domain
// gray pointer into the read clock through a flop chain, converts both
// pointers to binary and derives the empty flag, the read grant, the fill
// level with almost-empty, and a sticky underflow error.
//
// Optional feature macro: FIFO_RD_LEVEL_EN
//   defined     -> level_out / almost_empty_out are built and registered
//   not defined -> level_out and almost_empty_out are tied to zero and the
//                  level subtractor / threshold compare are not built
//
// Ports
//   clk               read-domain clock
//   rst_n_in          asynchronous active-low reset
//   wr_gray_in        write pointer (gray), asynchronous to clk
//   rd_gray_in        read pointer (gray) from the read-side gray counter
//   rd_en_in          read request from the consumer
//   rd_allow_out      read grant, rd_en_in & ~empty_out (combinational)
//   empty_out         registered empty flag
//   almost_empty_out  registered, level at or below AE_THRESH
//   level_out         registered entry count, 0..2^ADDR_WIDTH
//   underflow_out     sticky, read requested while empty
// ---------------------------------------------------------------------------
module fifo_rd_status #(
    parameter int ADDR_WIDTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AE_THRESH   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n_in,
    input  logic [ADDR_WIDTH:0]   wr_gray_in,
    input  logic [ADDR_WIDTH:0]   rd_gray_in,
    input  logic                  rd_en_in,
    output logic                  rd_allow_out,
    output logic                  empty_out,
    output logic                  almost_empty_out,
    output logic [ADDR_WIDTH:0]   level_out,
    output logic                  underflow_out
);

    localparam int PW = ADDR_WIDTH + 1;

    // Gray to binary: each binary bit is the xor of all gray bits at or above it.
    function automatic logic [ADDR_WIDTH:0] gray2bin(input logic [ADDR_WIDTH:0] g);
        logic [ADDR_WIDTH:0] b;
        b[ADDR_WIDTH] = g[ADDR_WIDTH];
        for (int i = ADDR_WIDTH - 1; i >= 0; i--) begin
            b[i] = b[i + 1] ^ g[i];
        end
        return b;
    endfunction

    logic [ADDR_WIDTH:0] r_sync [SYNC_STAGES];
    logic                r_empty;
    logic                r_underflow;

    logic [ADDR_WIDTH:0] w_wr_bin;
    logic [ADDR_WIDTH:0] w_rd_bin;
    logic [ADDR_WIDTH:0] w_rd_bin_nxt;
    logic                w_rd_allow;

    // Write-pointer synchroniser: plain flop chain, only the last stage is used.
    always_ff @(posedge clk or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= {PW{1'b0}};
            end
        end else begin
            r_sync[0] <= wr_gray_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i - 1];
            end
        end
    end

    // Pointer conversion and look-ahead read pointer. The read counter's
    // register moves on the same edge as r_empty, so the flag is computed
    // against the pointer value the counter is about to take.
    always_comb begin
        w_wr_bin     = gray2bin(r_sync[SYNC_STAGES - 1]);
        w_rd_bin     = gray2bin(rd_gray_in);
        w_rd_allow   = rd_en_in & ~r_empty;
        w_rd_bin_nxt = w_rd_bin + {{ADDR_WIDTH{1'b0}}, w_rd_allow};
    end

    // Empty flag and sticky underflow. Reset forces empty so no grant leaks
    // out while the counters are being cleared.
    always_ff @(posedge clk or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_empty     <= 1'b1;
            r_underflow <= 1'b0;
        end else begin
            r_empty     <= (w_rd_bin_nxt == w_wr_bin);
            r_underflow <= r_underflow | (rd_en_in & r_empty);
        end
    end

    assign rd_allow_out  = w_rd_allow;
    assign empty_out     = r_empty;
    assign underflow_out = r_underflow;

`ifdef FIFO_RD_LEVEL_EN
    localparam logic [ADDR_WIDTH:0] LP_AE_THRESH = PW'(AE_THRESH);

    logic [ADDR_WIDTH:0] r_level;
    logic                r_almost_empty;
    logic [ADDR_WIDTH:0] w_level_nxt;

    // Modulo subtraction handles pointer wrap through all-ones with no special case.
    always_comb begin
        w_level_nxt = w_wr_bin - w_rd_bin_nxt;
    end

    // Level and almost-empty registers, same latency as the empty flag.
    always_ff @(posedge clk or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_level        <= {PW{1'b0}};
            r_almost_empty <= 1'b1;
        end else begin
            r_level        <= w_level_nxt;
            r_almost_empty <= (w_level_nxt <= LP_AE_THRESH);
        end
    end

    assign level_out        = r_level;
    assign almost_empty_out = r_almost_empty;
`else
    assign level_out        = {PW{1'b0}};
    assign almost_empty_out = 1'b0;
`endif

endmodule
